multi_cycle_controller: RTL and testbench
=========================================

Name: multi_cycle_controller

Overview:
Moore-style control FSM for the next-generation multi-cycle MIPS core. It replaces the combinational single-cycle opcode decoder. It sequences one instruction over 3-5 states through a shared ALU and a single memory port, and stalls on a memory ready handshake. It sits beside the multi-cycle data path, takes the IR opcode and ALU zero flag, and drives every mux select and write enable.

Parameters:
ALUOP_W, 3, width of ALUOp bus; codes ADD=0, SUB=1, FUNCT=2, AND=3, OR=4, SLT=5, LUI=6.
MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = mem_ready treated as constant 1.
ENABLE_JAL, 1, 1 = jal (000011) supported; 0 = jal decoded as illegal.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  6  IR[31:26], stable from DECODE until instruction end
zero  in  1  ALU zero flag (combinational, current cycle)
mem_ready  in  1  memory completes the access this cycle
PCWrite  out  1  PC load enable (conditional in BRANCH)
IorD  out  1  0 = PC addresses memory, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  IR load enable
RegWrite  out  1  register file write enable
RegDst  out  2  00 = rt, 01 = rd, 10 = r31
MemtoReg  out  2  00 = ALUOut, 01 = MDR, 10 = PC
ALUSrcA  out  1  0 = PC, 1 = rs
ALUSrcB  out  2  00 = rt, 01 = const 4, 10 = ext imm, 11 = ext imm<<2
ALUOp  out  ALUOP_W  ALU operation code
Ext_op  out  1  1 = sign-extend, 0 = zero-extend immediate
PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
instr_done  out  1  one-cycle pulse in an instruction's final cycle
illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
state  out  4  current state encoding (debug)

Behaviour:
- State register updates on the rising clock edge. Outputs decode from state, opcode, zero and mem_ready. All outputs not listed for a state are 0.
- While reset=1: all outputs forced to 0 (state reads FETCH). The next edge loads FETCH. Reset mid-instruction abandons it and raises no pulses.
- FETCH(0): MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00. IRWrite=PCWrite=mem_ready. The FSM holds while mem_ready=0, otherwise goes to DECODE.
- DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=ADD, Ext_op=1 (branch target into ALUOut). Next state:
  - 000000 -> R_EXEC
  - 100011 and 101011 -> MEM_ADDR
  - 000100 and 000101 -> BRANCH
  - 001000, 001100, 001101, 001010, 001111 -> I_EXEC
  - 000010 and 000011 -> JUMP
  - anything else -> FETCH with illegal_op=1
- MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=ADD, Ext_op=1. lw goes to MEM_READ, sw goes to MEM_WRITE.
- MEM_READ(3): MemRead, IorD=1. Holds until mem_ready, then MEM_WB.
- MEM_WB(4): RegWrite, RegDst=00, MemtoReg=01, instr_done. Then FETCH.
- MEM_WRITE(5): MemWrite (level, held through wait), IorD=1. On mem_ready: instr_done, then FETCH.
- R_EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=FUNCT. Then R_WB.
- R_WB(7): RegWrite, RegDst=01, MemtoReg=00, instr_done. Then FETCH.
- I_EXEC(8): ALUSrcA=1, ALUSrcB=10. ALUOp and Ext_op by opcode:
  - addi: ADD, Ext_op=1
  - slti: SLT, Ext_op=1
  - andi: AND, Ext_op=0
  - ori: OR, Ext_op=0
  - lui: LUI, Ext_op=0
  - Then I_WB.
- I_WB(9): RegWrite, RegDst=00, MemtoReg=00, instr_done. Then FETCH.
- BRANCH(10): ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01, instr_done. PCWrite = zero for beq, ~zero for bne. Then FETCH.
- JUMP(11): PCWrite, PCSource=10, instr_done. For jal, also RegWrite, RegDst=10, MemtoReg=10; the old PC (already PC+4) is written on the same edge. Then FETCH.
- Cycle counts with zero wait:
  - lw: 5
  - sw, R-type, I-type: 4
  - branch and jump: 3
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- Unused encodings 12-15 go to FETCH on the next edge with all outputs 0.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - state encodings
  - opcode constants
  - ALUOp codes
  - RegDst, MemtoReg, ALUSrcB and PCSource select codes
- One natural sub-module: mc_output_decoder (combinational state/opcode/zero/mem_ready to control word). The FSM next-state logic stays in the top module.

Test Plan:
- Reset held 3 cycles, then R-type add with mem_ready=1 -> states 0,1,6,7,0. RegWrite=1, RegDst=01 only in state 7. instr_done pulses once in cycle 4.
- lw with mem_ready low 2 cycles in FETCH and 1 cycle in MEM_READ -> 8 total cycles. IRWrite and PCWrite high only in the ready cycle. MemtoReg=01 in MEM_WB.
- beq with zero=1 then bne with zero=1 -> PCWrite=1, PCSource=01 for beq; PCWrite=0 for bne. Both take 3 cycles.
- jal with ENABLE_JAL=1 -> JUMP has RegWrite=1, RegDst=10, MemtoReg=10, PCSource=10. With ENABLE_JAL=0 -> illegal_op pulse in DECODE, then FETCH, no instr_done.
- Opcode 111111 -> illegal_op=1 for one cycle in DECODE, then FETCH, no writes asserted.
- reset asserted during MEM_WRITE wait -> MemWrite drops to 0 that cycle and state=FETCH after the edge. With MEM_WAIT_EN=0 and mem_ready=0, lw still completes in 5 cycles.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes, ALU codes,
// mux select codes and the control word carried from the output decoder to the top.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAddr  = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StRExec    = 4'd6,
      StRWb      = 4'd7,
      StIExec    = 4'd8,
      StIWb      = 4'd9,
      StBranch   = 4'd10,
      StJump     = 4'd11
   } state_e;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpJal   = 6'b000011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpSlti  = 6'b001010;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpLui   = 6'b001111;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;

   localparam logic [2:0] AluAdd   = 3'd0;
   localparam logic [2:0] AluSub   = 3'd1;
   localparam logic [2:0] AluFunct = 3'd2;
   localparam logic [2:0] AluAnd   = 3'd3;
   localparam logic [2:0] AluOr    = 3'd4;
   localparam logic [2:0] AluSlt   = 3'd5;
   localparam logic [2:0] AluLui   = 3'd6;

   localparam logic [1:0] RegDstRt = 2'b00;
   localparam logic [1:0] RegDstRd = 2'b01;
   localparam logic [1:0] RegDstRa = 2'b10;

   localparam logic [1:0] MemtoRegAlu = 2'b00;
   localparam logic [1:0] MemtoRegMdr = 2'b01;
   localparam logic [1:0] MemtoRegPc  = 2'b10;

   localparam logic [1:0] SrcBRt    = 2'b00;
   localparam logic [1:0] SrcBFour  = 2'b01;
   localparam logic [1:0] SrcBImm   = 2'b10;
   localparam logic [1:0] SrcBImmSh = 2'b11;

   localparam logic [1:0] PcSrcAlu    = 2'b00;
   localparam logic [1:0] PcSrcAluOut = 2'b01;
   localparam logic [1:0] PcSrcJump   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       ext_op;
      logic [1:0] pc_source;
      logic       instr_done;
      logic       illegal_op;
   } ctrl_t;

   function automatic logic op_legal(input logic [5:0] op, input bit enable_jal);
      case (op)
         OpRtype, OpLw, OpSw, OpBeq, OpBne, OpJ,
         OpAddi, OpSlti, OpAndi, OpOri, OpLui: op_legal = 1'b1;
         OpJal:                                op_legal = enable_jal;
         default:                              op_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_output_decoder.sv
// Combinational control-word decode from the current state, IR opcode, ALU zero flag
// and the (already wait-qualified) memory ready.
module mc_output_decoder
   import mc_ctrl_pkg::*;
#(
   parameter bit ENABLE_JAL = 1'b1
) (
   input  state_e     state,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         StFetch: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SrcBFour;
            ctrl.alu_op    = AluAdd;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         StDecode: begin
            // Branch target is computed speculatively into ALUOut here.
            ctrl.alu_src_b  = SrcBImmSh;
            ctrl.alu_op     = AluAdd;
            ctrl.ext_op     = 1'b1;
            ctrl.illegal_op = ~op_legal(opcode, ENABLE_JAL);
         end
         StMemAddr: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBImm;
            ctrl.alu_op    = AluAdd;
            ctrl.ext_op    = 1'b1;
         end
         StMemRead: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         StMemWb: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = RegDstRt;
            ctrl.mem_to_reg = MemtoRegMdr;
            ctrl.instr_done = 1'b1;
         end
         StMemWrite: begin
            ctrl.mem_write  = 1'b1;
            ctrl.iord       = 1'b1;
            ctrl.instr_done = mem_ready;
         end
         StRExec: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBRt;
            ctrl.alu_op    = AluFunct;
         end
         StRWb: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = RegDstRd;
            ctrl.mem_to_reg = MemtoRegAlu;
            ctrl.instr_done = 1'b1;
         end
         StIExec: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBImm;
            case (opcode)
               OpAddi:  begin ctrl.alu_op = AluAdd; ctrl.ext_op = 1'b1; end
               OpSlti:  begin ctrl.alu_op = AluSlt; ctrl.ext_op = 1'b1; end
               OpAndi:  ctrl.alu_op = AluAnd;
               OpOri:   ctrl.alu_op = AluOr;
               OpLui:   ctrl.alu_op = AluLui;
               default: ctrl.alu_op = AluAdd;
            endcase
         end
         StIWb: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = RegDstRt;
            ctrl.mem_to_reg = MemtoRegAlu;
            ctrl.instr_done = 1'b1;
         end
         StBranch: begin
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = SrcBRt;
            ctrl.alu_op     = AluSub;
            ctrl.pc_source  = PcSrcAluOut;
            ctrl.pc_write   = (opcode == OpBne) ? ~zero : zero;
            ctrl.instr_done = 1'b1;
         end
         StJump: begin
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = PcSrcJump;
            ctrl.instr_done = 1'b1;
            // PC already holds PC+4, so the link value is written alongside the jump.
            if (ENABLE_JAL && (opcode == OpJal)) begin
               ctrl.reg_write  = 1'b1;
               ctrl.reg_dst    = RegDstRa;
               ctrl.mem_to_reg = MemtoRegPc;
            end
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS control FSM: sequences one instruction through 3-5 states, stalls on
// memory ready, and drives the data-path selects and write enables.
module multi_cycle_controller
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned ALUOP_W     = 3,
   parameter bit          MEM_WAIT_EN = 1'b1,
   parameter bit          ENABLE_JAL  = 1'b1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [5:0]         opcode,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic [1:0]         RegDst,
   output logic [1:0]         MemtoReg,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               Ext_op,
   output logic [1:0]         PCSource,
   output logic               instr_done,
   output logic               illegal_op,
   output logic [3:0]         state
);

   state_e state_q, state_d;
   ctrl_t  ctrl_raw, ctrl;
   logic   ready;

   assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

   always_comb begin
      state_d = StFetch;
      case (state_q)
         StFetch:    state_d = ready ? StDecode : StFetch;
         StDecode: begin
            if (op_legal(opcode, ENABLE_JAL)) begin
               case (opcode)
                  OpRtype:      state_d = StRExec;
                  OpLw, OpSw:   state_d = StMemAddr;
                  OpBeq, OpBne: state_d = StBranch;
                  OpJ, OpJal:   state_d = StJump;
                  default:      state_d = StIExec;
               endcase
            end
         end
         StMemAddr:  state_d = (opcode == OpSw) ? StMemWrite : StMemRead;
         StMemRead:  state_d = ready ? StMemWb : StMemRead;
         StMemWrite: state_d = ready ? StFetch : StMemWrite;
         StRExec:    state_d = StRWb;
         StIExec:    state_d = StIWb;
         default:    state_d = StFetch;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   mc_output_decoder #(
      .ENABLE_JAL(ENABLE_JAL)
   ) u_output_decoder (
      .state    (state_q),
      .opcode   (opcode),
      .zero     (zero),
      .mem_ready(ready),
      .ctrl     (ctrl_raw)
   );

   // Reset silences everything in the same cycle, so an abandoned instruction pulses nothing.
   assign ctrl  = reset ? '0 : ctrl_raw;
   assign state = reset ? 4'(StFetch) : 4'(state_q);

   assign PCWrite    = ctrl.pc_write;
   assign IorD       = ctrl.iord;
   assign MemRead    = ctrl.mem_read;
   assign MemWrite   = ctrl.mem_write;
   assign IRWrite    = ctrl.ir_write;
   assign RegWrite   = ctrl.reg_write;
   assign RegDst     = ctrl.reg_dst;
   assign MemtoReg   = ctrl.mem_to_reg;
   assign ALUSrcA    = ctrl.alu_src_a;
   assign ALUSrcB    = ctrl.alu_src_b;
   assign ALUOp      = ALUOP_W'(ctrl.alu_op);
   assign Ext_op     = ctrl.ext_op;
   assign PCSource   = ctrl.pc_source;
   assign instr_done = ctrl.instr_done;
   assign illegal_op = ctrl.illegal_op;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller: three configurations (default, no jal,
// no memory wait) share one stimulus stream; each cycle the full control word is compared.
module tb_multi_cycle_controller;

   logic       clock;
   logic       reset;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic [24:0] obs_w [3];

   int n_vec = 0;
   int n_err = 0;

   // Word layout: {PCWrite,IorD,MemRead,MemWrite,IRWrite,RegWrite, RegDst, MemtoReg,
   //               ALUSrcA, ALUSrcB, ALUOp, Ext_op, PCSource, instr_done,illegal_op, state}
   localparam logic [24:0] E_ZERO       = '0;
   localparam logic [24:0] E_FETCH_RDY  =
      {6'b101010, 2'b00, 2'b00, 1'b0, 2'b01, 3'd0, 1'b0, 2'b00, 2'b00, 4'd0};
   localparam logic [24:0] E_FETCH_WAIT =
      {6'b001000, 2'b00, 2'b00, 1'b0, 2'b01, 3'd0, 1'b0, 2'b00, 2'b00, 4'd0};
   localparam logic [24:0] E_DECODE     =
      {6'b000000, 2'b00, 2'b00, 1'b0, 2'b11, 3'd0, 1'b1, 2'b00, 2'b00, 4'd1};
   localparam logic [24:0] E_DECODE_ILL =
      {6'b000000, 2'b00, 2'b00, 1'b0, 2'b11, 3'd0, 1'b1, 2'b00, 2'b01, 4'd1};
   localparam logic [24:0] E_MEM_ADDR   =
      {6'b000000, 2'b00, 2'b00, 1'b1, 2'b10, 3'd0, 1'b1, 2'b00, 2'b00, 4'd2};
   localparam logic [24:0] E_MEM_READ   =
      {6'b011000, 2'b00, 2'b00, 1'b0, 2'b00, 3'd0, 1'b0, 2'b00, 2'b00, 4'd3};
   localparam logic [24:0] E_MEM_WB     =
      {6'b000001, 2'b00, 2'b01, 1'b0, 2'b00, 3'd0, 1'b0, 2'b00, 2'b10, 4'd4};
   localparam logic [24:0] E_MW_WAIT    =
      {6'b010100, 2'b00, 2'b00, 1'b0, 2'b00, 3'd0, 1'b0, 2'b00, 2'b00, 4'd5};
   localparam logic [24:0] E_MW_RDY     =
      {6'b010100, 2'b00, 2'b00, 1'b0, 2'b00, 3'd0, 1'b0, 2'b00, 2'b10, 4'd5};
   localparam logic [24:0] E_R_EXEC     =
      {6'b000000, 2'b00, 2'b00, 1'b1, 2'b00, 3'd2, 1'b0, 2'b00, 2'b00, 4'd6};
   localparam logic [24:0] E_R_WB       =
      {6'b000001, 2'b01, 2'b00, 1'b0, 2'b00, 3'd0, 1'b0, 2'b00, 2'b10, 4'd7};
   localparam logic [24:0] E_I_EXEC_ORI =
      {6'b000000, 2'b00, 2'b00, 1'b1, 2'b10, 3'd4, 1'b0, 2'b00, 2'b00, 4'd8};
   localparam logic [24:0] E_I_WB       =
      {6'b000001, 2'b00, 2'b00, 1'b0, 2'b00, 3'd0, 1'b0, 2'b00, 2'b10, 4'd9};
   localparam logic [24:0] E_BEQ_TAKEN  =
      {6'b100000, 2'b00, 2'b00, 1'b1, 2'b00, 3'd1, 1'b0, 2'b01, 2'b10, 4'd10};
   localparam logic [24:0] E_BNE_NOT    =
      {6'b000000, 2'b00, 2'b00, 1'b1, 2'b00, 3'd1, 1'b0, 2'b01, 2'b10, 4'd10};
   localparam logic [24:0] E_JAL        =
      {6'b100001, 2'b10, 2'b10, 1'b0, 2'b00, 3'd0, 1'b0, 2'b10, 2'b10, 4'd11};

   for (genvar g = 0; g < 3; g++) begin : gen_dut
      logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write;
      logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
      logic       alu_src_a, ext_op, instr_done, illegal_op;
      logic [2:0] alu_op;
      logic [3:0] state;

      multi_cycle_controller #(
         .ALUOP_W    (3),
         .MEM_WAIT_EN(g != 2),
         .ENABLE_JAL (g != 1)
      ) u_dut (
         .clock     (clock),
         .reset     (reset),
         .opcode    (opcode),
         .zero      (zero),
         .mem_ready (mem_ready),
         .PCWrite   (pc_write),
         .IorD      (iord),
         .MemRead   (mem_read),
         .MemWrite  (mem_write),
         .IRWrite   (ir_write),
         .RegWrite  (reg_write),
         .RegDst    (reg_dst),
         .MemtoReg  (mem_to_reg),
         .ALUSrcA   (alu_src_a),
         .ALUSrcB   (alu_src_b),
         .ALUOp     (alu_op),
         .Ext_op    (ext_op),
         .PCSource  (pc_source),
         .instr_done(instr_done),
         .illegal_op(illegal_op),
         .state     (state)
      );

      assign obs_w[g] = {pc_write, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
                         mem_to_reg, alu_src_a, alu_src_b, alu_op, ext_op, pc_source,
                         instr_done, illegal_op, state};
   end

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Compare one DUT's control word mid-cycle, then advance past the next rising edge.
   task automatic cyc(input string tag, input int g, input logic [24:0] exp);
      @(negedge clock);
      n_vec++;
      assert (obs_w[g] === exp)
      else begin
         n_err++;
         $error("FAIL %s (dut %0d): got %h expected %h", tag, g, obs_w[g], exp);
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      opcode    = 6'b000000;
      zero      = 1'b0;
      mem_ready = 1'b1;

      // Reset held three cycles: everything forced low even with mem_ready high.
      cyc("reset0", 0, E_ZERO);
      cyc("reset1", 0, E_ZERO);
      cyc("reset2", 0, E_ZERO);
      reset = 1'b0;

      // R-type add: 0,1,6,7
      opcode = 6'b000000;
      cyc("r_fetch", 0, E_FETCH_RDY);
      cyc("r_decode", 0, E_DECODE);
      cyc("r_exec", 0, E_R_EXEC);
      cyc("r_wb", 0, E_R_WB);

      // lw with two FETCH waits and one MEM_READ wait: 8 cycles
      opcode    = 6'b100011;
      mem_ready = 1'b0;
      cyc("lw_fetch_wait0", 0, E_FETCH_WAIT);
      cyc("lw_fetch_wait1", 0, E_FETCH_WAIT);
      mem_ready = 1'b1;
      cyc("lw_fetch_rdy", 0, E_FETCH_RDY);
      cyc("lw_decode", 0, E_DECODE);
      cyc("lw_addr", 0, E_MEM_ADDR);
      mem_ready = 1'b0;
      cyc("lw_read_wait", 0, E_MEM_READ);
      mem_ready = 1'b1;
      cyc("lw_read_rdy", 0, E_MEM_READ);
      cyc("lw_wb", 0, E_MEM_WB);

      // beq taken, then bne not taken, both with zero=1
      opcode = 6'b000100;
      zero   = 1'b1;
      cyc("beq_fetch", 0, E_FETCH_RDY);
      cyc("beq_decode", 0, E_DECODE);
      cyc("beq_branch", 0, E_BEQ_TAKEN);
      opcode = 6'b000101;
      cyc("bne_fetch", 0, E_FETCH_RDY);
      cyc("bne_decode", 0, E_DECODE);
      cyc("bne_branch", 0, E_BNE_NOT);
      zero = 1'b0;

      // jal with link write
      opcode = 6'b000011;
      cyc("jal_fetch", 0, E_FETCH_RDY);
      cyc("jal_decode", 0, E_DECODE);
      cyc("jal_jump", 0, E_JAL);

      // ori: zero-extended OR immediate
      opcode = 6'b001101;
      cyc("ori_fetch", 0, E_FETCH_RDY);
      cyc("ori_decode", 0, E_DECODE);
      cyc("ori_exec", 0, E_I_EXEC_ORI);
      cyc("ori_wb", 0, E_I_WB);

      // Illegal opcode: pulse in DECODE, straight back to FETCH
      opcode = 6'b111111;
      cyc("ill_fetch", 0, E_FETCH_RDY);
      cyc("ill_decode", 0, E_DECODE_ILL);

      // sw abandoned by reset during the MEM_WRITE wait
      opcode = 6'b101011;
      cyc("ill_then_fetch", 0, E_FETCH_RDY);
      cyc("sw_decode", 0, E_DECODE);
      cyc("sw_addr", 0, E_MEM_ADDR);
      mem_ready = 1'b0;
      cyc("sw_wait0", 0, E_MW_WAIT);
      cyc("sw_wait1", 0, E_MW_WAIT);
      reset = 1'b1;
      cyc("sw_reset_mid", 0, E_ZERO);
      reset     = 1'b0;
      mem_ready = 1'b1;

      // sw completing after one wait cycle
      cyc("sw2_fetch", 0, E_FETCH_RDY);
      cyc("sw2_decode", 0, E_DECODE);
      cyc("sw2_addr", 0, E_MEM_ADDR);
      mem_ready = 1'b0;
      cyc("sw2_wait", 0, E_MW_WAIT);
      mem_ready = 1'b1;
      cyc("sw2_rdy", 0, E_MW_RDY);
      cyc("sw2_next_fetch", 0, E_FETCH_RDY);

      // ENABLE_JAL=0: jal is illegal, no instr_done
      reset = 1'b1;
      cyc("nojal_reset", 1, E_ZERO);
      reset  = 1'b0;
      opcode = 6'b000011;
      cyc("nojal_fetch", 1, E_FETCH_RDY);
      cyc("nojal_decode", 1, E_DECODE_ILL);
      cyc("nojal_refetch", 1, E_FETCH_RDY);

      // MEM_WAIT_EN=0: lw finishes in 5 cycles with mem_ready held low
      reset = 1'b1;
      cyc("nowait_reset", 2, E_ZERO);
      reset     = 1'b0;
      opcode    = 6'b100011;
      mem_ready = 1'b0;
      cyc("nowait_fetch", 2, E_FETCH_RDY);
      cyc("nowait_decode", 2, E_DECODE);
      cyc("nowait_addr", 2, E_MEM_ADDR);
      cyc("nowait_read", 2, E_MEM_READ);
      cyc("nowait_wb", 2, E_MEM_WB);
      cyc("nowait_next_fetch", 2, E_FETCH_RDY);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
